// File: rtl/asym_fifo_read_wider_pkg.sv
// Shared sizing helpers for the asymmetric RAM/FIFO family (read-wider and write-wider variants).
package asym_fifo_read_wider_pkg;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned min_width(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned ratio(input int unsigned a, input int unsigned b);
    return max_width(a, b) / min_width(a, b);
  endfunction

  function automatic int unsigned log2_ratio(input int unsigned a, input int unsigned b);
    return log2(ratio(a, b));
  endfunction

endpackage

// File: rtl/asym_fifo_read_wider_ram.sv
// Simple dual-port RAM: narrow per-lane write port, wide registered read port with enable.
module asym_ram_sdp_read_wider
  import asym_fifo_read_wider_pkg::*;
#(
  parameter int unsigned WIDTHA     = 4,
  parameter int unsigned WIDTHB     = 16,
  parameter int unsigned DEPTHB     = 256,
  parameter int unsigned ADDRWIDTHB = 8,
  localparam int unsigned RATIO     = ratio(WIDTHA, WIDTHB),
  localparam int unsigned LOG2RATIO = log2(RATIO)
) (
  input  logic                            clkB,
  input  logic                            rst,
  input  logic                            wrEn,
  input  logic [ADDRWIDTHB+LOG2RATIO-1:0] addrA,
  input  logic [WIDTHA-1:0]               dinA,
  input  logic                            rdEn,
  input  logic [ADDRWIDTHB-1:0]           addrB,
  output logic [WIDTHB-1:0]               doutB
);

  logic [WIDTHB-1:0]     mem [DEPTHB];
  logic [ADDRWIDTHB-1:0] wordA;
  logic [LOG2RATIO-1:0]  laneA;

  assign wordA = addrA[ADDRWIDTHB+LOG2RATIO-1 -: ADDRWIDTHB];
  assign laneA = addrA[LOG2RATIO-1:0];

  // Lane-enable write so synthesis maps it onto BRAM byte/lane write enables.
  always_ff @(posedge clkB) begin
    if (wrEn) begin
      for (int unsigned l = 0; l < RATIO; l++) begin
        if (laneA == LOG2RATIO'(l)) mem[wordA][l*WIDTHA +: WIDTHA] <= dinA;
      end
    end
  end

  always_ff @(posedge clkB) begin
    if (rst) begin
      doutB <= '0;
    end else if (rdEn) begin
      doutB <= mem[addrB];
    end
  end

endmodule

// File: rtl/asym_fifo_read_wider.sv
// Single-clock FIFO: narrow words in, LSB-first packed wide words out through a registered RAM read.
module asym_fifo_read_wider
  import asym_fifo_read_wider_pkg::*;
#(
  parameter int unsigned DATAWIDTHA  = 4,
  parameter int unsigned DATAWIDTHB  = 16,
  parameter int unsigned DEPTHB      = 256,
  parameter int unsigned ADDRWIDTHB  = 8,
  localparam int unsigned RATIO      = ratio(DATAWIDTHA, DATAWIDTHB),
  localparam int unsigned LOG2RATIO  = log2(RATIO),
  localparam int unsigned LEVELWIDTH = ADDRWIDTHB + LOG2RATIO + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATAWIDTHA-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATAWIDTHB-1:0] rd_data,
  output logic [LEVELWIDTH-1:0] level,
  output logic                  partial
);

  localparam logic [LEVELWIDTH-1:0] CAPACITY = LEVELWIDTH'(DEPTHB * RATIO);
  localparam logic [LEVELWIDTH-1:0] GROUP    = LEVELWIDTH'(RATIO);

  logic [LEVELWIDTH-1:0] wrPtrQ;
  logic [ADDRWIDTHB:0]   rdPtrQ;
  logic                  rdValidQ;
  logic                  push;
  logic                  fetch;

  // Read pointer counts wide words; scale it to narrow units to form the level.
  assign level    = wrPtrQ - {rdPtrQ, {LOG2RATIO{1'b0}}};
  assign partial  = |level[LOG2RATIO-1:0];
  assign wr_ready = !rst && (level < CAPACITY);
  assign rd_valid = rdValidQ && !rst;
  assign push     = wr_valid && wr_ready;
  assign fetch    = (level >= GROUP) && (!rdValidQ || rd_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      rdValidQ <= 1'b0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + LEVELWIDTH'(1);
      if (fetch) begin
        rdPtrQ   <= rdPtrQ + (ADDRWIDTHB + 1)'(1);
        rdValidQ <= 1'b1;
      end else if (rd_ready) begin
        rdValidQ <= 1'b0;
      end
    end
  end

  asym_ram_sdp_read_wider #(
    .WIDTHA     (DATAWIDTHA),
    .WIDTHB     (DATAWIDTHB),
    .DEPTHB     (DEPTHB),
    .ADDRWIDTHB (ADDRWIDTHB)
  ) u_ram (
    .clkB  (clk),
    .rst   (rst),
    .wrEn  (push),
    .addrA (wrPtrQ[LEVELWIDTH-2:0]),
    .dinA  (wr_data),
    .rdEn  (fetch),
    .addrB (rdPtrQ[ADDRWIDTHB-1:0]),
    .doutB (rd_data)
  );

endmodule

// File: tb/tb_asym_fifo_read_wider.sv
// Scenario bench for asym_fifo_read_wider with a packing scoreboard.
module tb_asym_fifo_read_wider;

  localparam int unsigned DWA = 4;
  localparam int unsigned DWB = 16;
  localparam int unsigned LW  = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_valid = 1'b0;
  logic           rd_ready = 1'b0;
  logic [DWA-1:0] wr_data = '0;
  logic           wr_ready, rd_valid, partial;
  logic [DWB-1:0] rd_data;
  logic [LW-1:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DWB-1:0] exp_q[$];
  logic [DWB-1:0] grp = '0;
  int             nl = 0;
  logic [DWB-1:0] expd;

  logic           s_acc, s_pop, s_valid, s_partial, s_wr_ready;
  logic [DWA-1:0] s_wd;
  logic [DWB-1:0] s_data;
  logic [LW-1:0]  s_level;

  always #5 clk = ~clk;

  asym_fifo_read_wider #(
    .DATAWIDTHA (4),
    .DATAWIDTHB (16),
    .DEPTHB     (256),
    .ADDRWIDTHB (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .partial  (partial)
  );

  // Sample everything mid-cycle, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_acc      = wr_valid && wr_ready;
    s_pop      = rd_valid && rd_ready;
    s_wd       = wr_data;
    s_valid    = rd_valid;
    s_data     = rd_data;
    s_level    = level;
    s_partial  = partial;
    s_wr_ready = wr_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [DWA-1:0] d);
    grp[nl*DWA +: DWA] = d;
    nl++;
    if (nl == int'(DWB / DWA)) begin
      exp_q.push_back(grp);
      nl  = 0;
      grp = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    nl  = 0;
    grp = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    tick();
    tick();
    n_tests++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready: got %b required 0", s_wr_ready); end
    n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b required 0", s_valid); end
    rst = 1'b0;
    tick();
    n_tests++; if (s_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d required 0", s_level); end
    n_tests++; if (s_partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b required 0", s_partial); end
    n_tests++; if (s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b required 1", s_wr_ready); end
    n_tests++; if (s_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h required 0000", s_data); end
    model_reset();
  endtask

  task automatic test_basic_pack();
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = (i < 4);
      wr_data  = DWA'(i + 1);
      tick();
      if (s_acc) model_push(s_wd);
      if (i >= 1 && i <= 4) begin
        n_tests++;
        if (s_partial !== (i < 4) || s_level !== LW'(i)) begin
          n_fail++; $display("FAIL basic_partial_%0d: got partial=%b level=%0d required partial=%b level=%0d", i, s_partial, s_level, (i < 4), i);
        end
      end
      if (i == 4) begin
        n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: got rd_valid=%b required 0", s_valid); end
      end
      if (i == 5) begin
        n_tests++; if (s_valid !== 1'b1 || s_data !== 16'h4321) begin n_fail++; $display("FAIL basic_word: got valid=%b data=%h required valid=1 data=4321", s_valid, s_data); end
      end
      if (s_pop) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_pop: got %h required no pop", s_data); end
        else begin expd = exp_q.pop_front(); if (s_data !== expd) begin n_fail++; $display("FAIL basic_data: got %h required %h", s_data, expd); end end
      end
    end
  endtask

  task automatic test_partial_hold();
    bit seen_valid = 0;
    bit popped = 0;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = DWA'(10 + i);
      tick();
      if (s_acc) model_push(s_wd);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (s_valid) seen_valid = 1;
    end
    n_tests++; if (seen_valid) begin n_fail++; $display("FAIL hold_rd_valid: got 1 required 0 for 100 cycles"); end
    n_tests++; if (s_level !== LW'(3)) begin n_fail++; $display("FAIL hold_level: got %0d required 3", s_level); end
    wr_valid = 1'b1; wr_data = 4'hD;
    tick();
    if (s_acc) model_push(s_wd);
    wr_valid = 1'b0;
    for (int i = 0; i < 6 && !popped; i++) begin
      tick();
      if (s_pop) begin
        popped = 1;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL hold_pop: got %h required no pop", s_data); end
        else begin expd = exp_q.pop_front(); if (s_data !== expd) begin n_fail++; $display("FAIL hold_data: got %h required %h", s_data, expd); end end
      end
    end
    n_tests++; if (!popped) begin n_fail++; $display("FAIL hold_release: got no pop required a pop"); end
  endtask

  task automatic test_full();
    int cnt = 0;
    int cyc = 0;
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      wr_data = DWA'($urandom);
      tick();
      if (s_acc) begin model_push(s_wd); cnt++; end
      if (!s_wr_ready) break;
    end
    wr_valid = 1'b0;
    n_tests++; if (cnt != 1028) begin n_fail++; $display("FAIL full_count: got %0d required 1028", cnt); end
    n_tests++; if (s_level !== LW'(1024) || s_valid !== 1'b1) begin n_fail++; $display("FAIL full_state: got level=%0d valid=%b required level=1024 valid=1", s_level, s_valid); end
    rd_ready = 1'b1;
    tick();
    n_tests++; if (s_wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_pop_cycle: got %b required 0", s_wr_ready); end
    if (s_pop) begin
      n_tests++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL full_pop: got %h required no pop", s_data); end
      else begin expd = exp_q.pop_front(); if (s_data !== expd) begin n_fail++; $display("FAIL full_data: got %h required %h", s_data, expd); end end
    end
    rd_ready = 1'b0;
    tick();
    n_tests++; if (s_wr_ready !== 1'b1 || s_level !== LW'(1020)) begin n_fail++; $display("FAIL full_reassert: got ready=%b level=%0d required ready=1 level=1020", s_wr_ready, s_level); end
    rd_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 2000) begin
      tick(); cyc++;
      if (s_pop) begin
        n_tests++;
        expd = exp_q.pop_front();
        if (s_data !== expd) begin n_fail++; $display("FAIL full_drain_data: got %h required %h", s_data, expd); end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain_timeout: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DWB-1:0] held;
    bit stable = 1;
    int cyc = 0;
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = DWA'($urandom);
      tick();
      if (s_acc) model_push(s_wd);
    end
    wr_valid = 1'b0;
    tick();
    held = s_data;
    n_tests++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", s_valid); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_data !== held || s_valid !== 1'b1) stable = 0;
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL bp_stable: got data=%h required %h held", s_data, held); end
    rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++; if (s_pop !== 1'b1) begin n_fail++; $display("FAIL bp_pop_%0d: got pop=%b required 1", i, s_pop); end
      if (s_pop) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_pop: got %h required no pop", s_data); end
        else begin expd = exp_q.pop_front(); if (s_data !== expd) begin n_fail++; $display("FAIL bp_data: got %h required %h", s_data, expd); end end
      end
    end
    while (exp_q.size() > 0 && cyc < 20) begin
      tick(); cyc++;
      if (s_pop) begin expd = exp_q.pop_front(); n_tests++; if (s_data !== expd) begin n_fail++; $display("FAIL bp_drain: got %h required %h", s_data, expd); end end
    end
  endtask

  task automatic test_stream();
    int acc_n = 0;
    int cyc = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      wr_valid = (acc_n < 10000) && ($urandom_range(0, 1) == 1);
      wr_data  = DWA'($urandom);
      rd_ready = ($urandom_range(0, 1) == 1);
      tick(); cyc++;
      if (s_acc) begin model_push(s_wd); acc_n++; end
      if (s_pop) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_pop: got %h required no pop", s_data); end
        else begin expd = exp_q.pop_front(); if (s_data !== expd) begin n_fail++; $display("FAIL stream_data: got %h required %h", s_data, expd); end end
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      tick(); cyc++;
      if (s_pop) begin
        n_tests++;
        expd = exp_q.pop_front();
        if (s_data !== expd) begin n_fail++; $display("FAIL stream_drain: got %h required %h", s_data, expd); end
      end
    end
    tick();
    n_tests++; if (exp_q.size() != 0 || s_level !== '0) begin n_fail++; $display("FAIL stream_end: got left=%0d level=%0d required 0 and 0", exp_q.size(), s_level); end
  endtask

  task automatic test_reset_mid();
    bit popped = 0;
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 41; i++) begin
      wr_data = DWA'($urandom);
      tick();
      if (s_acc) model_push(s_wd);
    end
    wr_valid = 1'b0;
    tick();
    n_tests++; if (s_level !== LW'(37) || s_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got level=%0d valid=%b required 37 and 1", s_level, s_valid); end
    rst = 1'b1;
    tick();
    n_tests++; if (s_wr_ready !== 1'b0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_during: got ready=%b valid=%b required 0 and 0", s_wr_ready, s_valid); end
    rst = 1'b0;
    model_reset();
    tick();
    n_tests++; if (s_level !== '0 || s_valid !== 1'b0 || s_data !== '0 || s_partial !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got level=%0d valid=%b data=%h partial=%b required 0", s_level, s_valid, s_data, s_partial);
    end
    rd_ready = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 10 && !popped; i++) begin
      wr_valid = (i < 4);
      wr_data  = DWA'($urandom);
      tick();
      if (s_acc) model_push(s_wd);
      if (s_pop) begin
        popped = 1;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL mid_pop: got %h required no pop", s_data); end
        else begin expd = exp_q.pop_front(); if (s_data !== expd) begin n_fail++; $display("FAIL mid_data: got %h required %h", s_data, expd); end end
      end
    end
    wr_valid = 1'b0;
    n_tests++; if (!popped) begin n_fail++; $display("FAIL mid_first_group: got no pop required a pop"); end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_partial_hold();
    test_full();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
